// File: rtl/piso_shift_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : piso_shift_tx                                          |
// | Description : Parallel-in, serial-out transmit register. Captures a  |
// |               WIDTH-bit word on a valid/ready load handshake and     |
// |               shifts it out one bit per accepted serial beat.        |
// |               Optional even-parity beat: PISO_SHIFT_TX_PARITY_EN.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  // Counter value of the last data bit, and of the final beat of the word.
  localparam logic [c_cnt_w-1:0] c_last_data_cnt = c_cnt_w'(WIDTH - 1);
`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam logic [c_cnt_w-1:0] c_final_cnt = c_cnt_w'(WIDTH);
`else
  localparam logic [c_cnt_w-1:0] c_final_cnt = c_cnt_w'(WIDTH - 1);
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_shift, w_shift_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_ser_valid, w_ser_valid_nxt;
  logic                 r_ser_last, w_ser_last_nxt;
  logic                 r_load_ready, w_load_ready_nxt;
  logic [WIDTH-1:0]     w_shift_adv;
  logic [c_cnt_w-1:0]   w_cnt_inc;
  logic                 w_beat;
`ifdef PISO_SHIFT_TX_PARITY_EN
  logic                 r_parity, w_parity_nxt;
  logic [WIDTH-1:0]     w_parity_word;
`endif

  // The outgoing bit always sits at the exit end of the shift register, so
  // ser_out is a pure register tap and cannot see ser_ready or load_valid.
  assign ser_out    = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
  assign ser_valid  = r_ser_valid;
  assign ser_last   = r_ser_last;
  assign load_ready = r_load_ready;

  assign w_beat      = r_ser_valid & ser_ready;
  assign w_cnt_inc   = r_cnt + c_cnt_w'(1);
  assign w_shift_adv = LSB_FIRST ? {1'b0, r_shift[WIDTH-1:1]}
                                 : {r_shift[WIDTH-2:0], 1'b0};
`ifdef PISO_SHIFT_TX_PARITY_EN
  // Parity bit placed at the exit end, ready to become ser_out.
  assign w_parity_word = LSB_FIRST ? {{(WIDTH-1){1'b0}}, r_parity}
                                   : {r_parity, {(WIDTH-1){1'b0}}};
`endif

  // Next-state and next-output logic; every target holds by default.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_ser_valid_nxt  = r_ser_valid;
    w_ser_last_nxt   = r_ser_last;
    w_load_ready_nxt = r_load_ready;
`ifdef PISO_SHIFT_TX_PARITY_EN
    w_parity_nxt     = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_state_nxt      = SHIFT;
          w_shift_nxt      = load_data;
          w_cnt_nxt        = '0;
          w_ser_valid_nxt  = 1'b1;
          w_ser_last_nxt   = 1'b0;
          w_load_ready_nxt = 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
          w_parity_nxt     = ^load_data;
`endif
        end
      end
      SHIFT: begin
        if (w_beat) begin
          if (r_cnt == c_final_cnt) begin
            // Final beat accepted: drop the word and reopen the load port.
            w_state_nxt      = IDLE;
            w_shift_nxt      = '0;
            w_ser_valid_nxt  = 1'b0;
            w_ser_last_nxt   = 1'b0;
            w_load_ready_nxt = 1'b1;
          end else begin
            w_cnt_nxt      = w_cnt_inc;
            w_ser_last_nxt = (w_cnt_inc == c_final_cnt);
`ifdef PISO_SHIFT_TX_PARITY_EN
            w_shift_nxt    = (r_cnt == c_last_data_cnt) ? w_parity_word
                                                        : w_shift_adv;
`else
            w_shift_nxt    = w_shift_adv;
`endif
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; clear overrides everything.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_ser_valid  <= 1'b0;
      r_ser_last   <= 1'b0;
      r_load_ready <= 1'b1;
`ifdef PISO_SHIFT_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ser_valid  <= w_ser_valid_nxt;
      r_ser_last   <= w_ser_last_nxt;
      r_load_ready <= w_load_ready_nxt;
`ifdef PISO_SHIFT_TX_PARITY_EN
      r_parity     <= w_parity_nxt;
`endif
    end
  end

`ifndef PISO_SHIFT_TX_PARITY_EN
  // Only the parity build advances onto a beat after the last data bit.
  logic w_unused_last_data_cnt;
  assign w_unused_last_data_cnt = ^c_last_data_cnt;
`endif

endmodule
`default_nettype wire
